// File: rtl/sos_sequencer.sv
// Letter-level SOS sequencer: tracks S -> O -> S within a gap window, flags and counts
// completed SOS events, and requests a detector clear after every abort.
module sos_sequencer #(
  parameter int GAP_MAX = 16,
  parameter int CNT_W   = 8,
  parameter bit OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s_hit,
  input  logic             o_hit,
  input  logic             cnt_clr,
  output logic             sos,
  output logic             timeout_err,
  output logic             proto_err,
  output logic             det_clr,
  output logic             busy,
  output logic [2:0]       current_state,
  output logic [CNT_W-1:0] sos_count
);

  localparam int GW = $clog2(GAP_MAX);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    GOT_S  = 3'b001,
    GOT_SO = 3'b010,
    DONE   = 3'b011
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [GW-1:0] gap_r, gap_nxt_s;
  logic          timeout_r, proto_r, det_clr_r;
  logic          timeout_nxt_s, proto_nxt_s, det_clr_nxt_s;
  logic          both_s, s_only_s, o_only_s, expire_s;

  // Next-state, gap timer and error-pulse decode
  always_comb begin
    state_nxt_s   = state_r;
    gap_nxt_s     = gap_r;
    timeout_nxt_s = 1'b0;
    proto_nxt_s   = 1'b0;
    det_clr_nxt_s = 1'b0;
    both_s   = en & s_hit & o_hit;
    s_only_s = en & s_hit & ~o_hit;
    o_only_s = en & o_hit & ~s_hit;
    expire_s = (gap_r == GAP_LAST);
    if (both_s) begin
      state_nxt_s   = IDLE;
      gap_nxt_s     = {GW{1'b0}};
      proto_nxt_s   = 1'b1;
      det_clr_nxt_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (s_only_s) begin
            state_nxt_s = GOT_S;
            gap_nxt_s   = {GW{1'b0}};
          end else begin
            state_nxt_s = IDLE;
          end
        end
        GOT_S, GOT_SO: begin
          if (s_only_s) begin
            state_nxt_s = (state_r == GOT_SO) ? DONE : GOT_S;
            gap_nxt_s   = {GW{1'b0}};
          end else if (o_only_s) begin
            state_nxt_s   = (state_r == GOT_S) ? GOT_SO : IDLE;
            det_clr_nxt_s = (state_r == GOT_SO);
            gap_nxt_s     = {GW{1'b0}};
          end else if (en) begin
            // quiet enabled cycle: a hit in the threshold cycle would have won above
            if (expire_s) begin
              state_nxt_s   = IDLE;
              gap_nxt_s     = {GW{1'b0}};
              timeout_nxt_s = 1'b1;
              det_clr_nxt_s = 1'b1;
            end else begin
              gap_nxt_s = gap_r + GW'(1);
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        DONE: begin
          state_nxt_s = OVERLAP ? GOT_S : IDLE;
          gap_nxt_s   = {GW{1'b0}};
        end
        default: begin
          state_nxt_s = IDLE;
          gap_nxt_s   = {GW{1'b0}};
        end
      endcase
    end
  end

  // State, timer and registered error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      gap_r     <= {GW{1'b0}};
      timeout_r <= 1'b0;
      proto_r   <= 1'b0;
      det_clr_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      gap_r     <= gap_nxt_s;
      timeout_r <= timeout_nxt_s;
      proto_r   <= proto_nxt_s;
      det_clr_r <= det_clr_nxt_s;
    end
  end

  // Saturating SOS counter; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst) begin
      sos_count <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      sos_count <= {CNT_W{1'b0}};
    end else if ((state_nxt_s == DONE) && (state_r != DONE) && (sos_count != CNT_FULL)) begin
      sos_count <= sos_count + CNT_W'(1);
    end else begin
      sos_count <= sos_count;
    end
  end

  assign sos           = (state_r == DONE);
  assign busy          = (state_r != IDLE);
  assign current_state = state_r;
  assign timeout_err   = timeout_r;
  assign proto_err     = proto_r;
  assign det_clr       = det_clr_r;

endmodule
